boot_uart_rx: RTL and testbench
===============================

Name: boot_uart_rx

Overview:
- Serial byte receiver on the boot-programming path, directly upstream of iccm_controller.
- Feeds it a one-cycle byte-valid strobe plus byte (8N1 framing, LSB first).
- Bit period is set at run time in system clocks (10417 for current clk/baud).
- Adds what the boot path lacks: metastability synchronizer, mid-bit start-glitch rejection, frame-error and break reporting.

Parameters:
- CntW, 16, width of bit-period counter and clks_per_bit_i.
- SyncStages, 2, flop stages on rx_i; legal values are 2 or 3.
- MinCpb, 4, smallest bit period honoured; smaller programmed values are clamped to this.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- rx_i  input  1  raw serial line, idle high, asynchronous to clk_i.
- clks_per_bit_i  input  CntW  bit period in clk_i cycles.
- rx_dv_o  output  1  one-cycle strobe: rx_byte_o holds a new valid byte.
- rx_byte_o  output  8  last good byte; holds until next rx_dv_o.
- frame_err_o  output  1  one-cycle strobe: stop bit sampled low.
- break_o  output  1  level: line held low past a frame error; clears when line returns high.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous, active-low, single clock clk_i.
- Reset values: rx_dv_o=0, rx_byte_o=8'h00, frame_err_o=0, break_o=0, busy_o=0. Synchronizer flops reset to 1, state=IDLE, counters=0.
- rx_s is rx_i after SyncStages flops. All decisions use rx_s only.
- cpb_q latches max(clks_per_bit_i, MinCpb) on leaving IDLE. Changes to clks_per_bit_i mid-frame are ignored.
- half = (cpb_q-1)>>1. For cpb_q=10417, half=5208.
- IDLE:
  - cnt=0. If rx_s==0 -> START, cnt=0.
- START:
  - cnt++ each cycle.
  - At cnt==half: rx_s==0 -> DATA, cnt=0, idx=0. Otherwise this is a glitch -> IDLE with no strobe.
- DATA:
  - At cnt==cpb_q-1: shift_q[idx]=rx_s, cnt=0.
  - idx==7 -> STOP, else idx++. Otherwise cnt++.
  - Samples therefore land at bit centres.
- STOP:
  - At cnt==cpb_q-1:
    - rx_s==1: rx_byte_o<=shift_q and rx_dv_o<=1 on the same edge -> IDLE.
    - rx_s==0: frame_err_o<=1, rx_byte_o unchanged -> WAIT_HIGH.
- WAIT_HIGH:
  - break_o=1 while here. rx_s==1 -> IDLE, break_o<=0.
- Strobes: rx_dv_o and frame_err_o are registered, high exactly one cycle, never both in the same cycle.
- Latency: the strobe is visible one clock after the stop-bit centre sample edge.
- Back-to-back frames: IDLE is re-entered at stop-bit centre, so a start edge arriving half a bit later is accepted. No frames are lost at full line rate.
- busy_o = (state!=IDLE), registered with state.
- Reset mid-frame: partial byte discarded, no strobe, outputs return to reset values immediately.
- Counters never wrap: cnt is compared for equality against a value ≤ cpb_q-1 < 2^CntW.

Decomposition:
- Shared package boot_uart_pkg:
  - state enum {IDLE, START, DATA, STOP, WAIT_HIGH}, 3 bits.
  - Constant DefaultCpb=16'd10417.
- One sub-module: boot_uart_rx_sync, a SyncStages-deep flop chain, reset value 1, no logic. It is kept separate so it can be swapped for a library synchronizer cell.
- Everything else (FSM, counters, shift register) stays in boot_uart_rx.

Test Plan:
- Byte framing: cpb=16, send 0xA5 (8N1) -> rx_dv_o one cycle, rx_byte_o=8'hA5, frame_err_o stays 0, busy_o high from start edge plus SyncStages until the strobe.
- Start glitch: cpb=16, rx_i low for 5 cycles, then high -> START aborts at half=7, no rx_dv_o/frame_err_o, busy_o back to 0; a following 0x3C is received correctly.
- Frame error and break:
  - Send 0x55 with stop bit low, line held low 40 cycles -> frame_err_o pulse, rx_byte_o keeps previous value, break_o high until line high.
  - Then 0x81 -> rx_dv_o, rx_byte_o=8'h81.
- Back-to-back and clamp:
  - cpb=16, 0x00 then 0xFF with zero idle gap -> two rx_dv_o strobes 160 cycles apart, bytes 0x00 then 0xFF.
  - Repeat with clks_per_bit_i=2 -> behaves as cpb=4.
- Reset mid-frame: assert rst_ni low during DATA bit 4 of 0xC3, release, send 0x5A -> no strobe for 0xC3, rx_byte_o=8'h00 after reset, then rx_dv_o with 8'h5A.
- Mid-frame cpb change: switch clks_per_bit_i 16->32 during DATA -> current byte decoded at cpb 16, next byte at cpb 32.

Source files
------------

// File: rtl/boot_uart_pkg.sv
// rtl/boot_uart_pkg.sv - shared types and constants for the boot UART receiver
//
// Purpose : receiver state encoding and the default bit period for the
//           current system clock / baud pairing.
// Ports   : none (package).

package boot_uart_pkg;

  // Receiver states; 3 bits holds all five with room to spare.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

  // Bit period in system clocks for the current clk/baud combination.
  localparam logic [15:0] DefaultCpb = 16'd10417;

endpackage

// File: rtl/boot_uart_rx_sync.sv
// rtl/boot_uart_rx_sync.sv - plain flop-chain synchronizer for the serial line
//
// Purpose : brings the asynchronous rx line into the clk_i domain through
//           Stages flops. Kept as its own module so a library synchronizer
//           cell can replace it without touching the receiver.
// Ports   : clk_i  - system clock
//           rst_ni - asynchronous active-low reset (flops reset to 1, line idle)
//           d_i    - asynchronous input
//           q_o    - synchronized output
// Stages must be 2 or 3.

module boot_uart_rx_sync #(
  parameter int Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;
  logic [Stages-1:0] sync_d;

  // Pure shift: each flop takes the previous one, first flop takes the pin.
  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/boot_uart_rx.sv
// rtl/boot_uart_rx.sv - 8N1 serial byte receiver for the boot-programming path
//
// Purpose : receives LSB-first 8N1 frames with a run-time bit period and hands
//           each good byte downstream with a one-cycle strobe. Rejects start
//           glitches shorter than half a bit, reports framing errors and a
//           held-low (break) line.
// Ports   : clk_i          - system clock
//           rst_ni         - asynchronous active-low reset
//           rx_i           - raw serial line, idle high, asynchronous
//           clks_per_bit_i - bit period in clk_i cycles (clamped to MinCpb)
//           rx_dv_o        - one-cycle strobe, rx_byte_o holds a new byte
//           rx_byte_o      - last good byte, held until the next rx_dv_o
//           frame_err_o    - one-cycle strobe, stop bit sampled low
//           break_o        - level, line still low after a framing error
//           busy_o         - receiver is not idle

module boot_uart_rx
  import boot_uart_pkg::*;
#(
  parameter int CntW       = 16,
  parameter int SyncStages = 2,
  parameter int MinCpb     = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            rx_i,
  input  logic [CntW-1:0] clks_per_bit_i,
  output logic            rx_dv_o,
  output logic [7:0]      rx_byte_o,
  output logic            frame_err_o,
  output logic            break_o,
  output logic            busy_o
);

  localparam logic [CntW-1:0] MinCpbW = CntW'(MinCpb);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic rx_s;

  boot_uart_rx_sync #(
    .Stages (SyncStages)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] cpb_q, cpb_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_dv_q, rx_dv_d;
  logic            frame_err_q, frame_err_d;
  logic            break_q, break_d;
  logic            busy_q, busy_d;

  logic [CntW-1:0] cpb_clamped;
  logic [CntW-1:0] half;
  logic [CntW-1:0] last_cnt;

  // Very small programmed periods cannot place a mid-bit sample; clamp them.
  assign cpb_clamped = (clks_per_bit_i < MinCpbW) ? MinCpbW : clks_per_bit_i;

  // Start bit is re-checked at its centre; data/stop samples then fall one
  // full period apart, i.e. at each bit centre.
  assign half     = (cpb_q - CntOne) >> 1;
  assign last_cnt = cpb_q - CntOne;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cpb_d       = cpb_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    rx_dv_d     = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
          // Period is frozen for the whole frame from here on.
          cpb_d   = cpb_clamped;
        end
      end

      START: begin
        if (cnt_q == half) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = 3'd0;
          end else begin
            // Line went back high before mid-bit: glitch, drop silently.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      DATA: begin
        if (cnt_q == last_cnt) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      STOP: begin
        if (cnt_q == last_cnt) begin
          cnt_d = '0;
          if (rx_s) begin
            rx_byte_d = shift_q;
            rx_dv_d   = 1'b1;
            // Back to IDLE at stop-bit centre so the next start edge,
            // half a bit away, is never missed.
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Level outputs are registered alongside the state they describe.
    busy_d  = (state_d != IDLE);
    break_d = (state_d == WAIT_HIGH);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cpb_q       <= CntW'(DefaultCpb);
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      rx_byte_q   <= 8'h00;
      rx_dv_q     <= 1'b0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpb_q       <= cpb_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_dv_q     <= rx_dv_d;
      frame_err_q <= frame_err_d;
      break_q     <= break_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_dv_o     = rx_dv_q;
  assign rx_byte_o   = rx_byte_q;
  assign frame_err_o = frame_err_q;
  assign break_o     = break_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_boot_uart_rx.sv
// tb/tb_boot_uart_rx.sv - self-checking bench for boot_uart_rx

module tb_boot_uart_rx;

  localparam int S      = 2;
  localparam int MinCpb = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        rx_i = 1'b1;
  logic [15:0] clks_per_bit_i = 16'd16;
  logic        rx_dv_o;
  logic [7:0]  rx_byte_o;
  logic        frame_err_o;
  logic        break_o;
  logic        busy_o;

  boot_uart_rx #(
    .CntW       (16),
    .SyncStages (S),
    .MinCpb     (MinCpb)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .rx_i           (rx_i),
    .clks_per_bit_i (clks_per_bit_i),
    .rx_dv_o        (rx_dv_o),
    .rx_byte_o      (rx_byte_o),
    .frame_err_o    (frame_err_o),
    .break_o        (break_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    int         cpb;
    bit         stop_ok;
    int         hold;
    int         gap;
    logic [7:0] exp_byte;
    bit         exp_ferr;
  } vec_t;

  ev_t        obs[$];
  ev_t        exp_q[$];
  int         cyc = 0;
  int         ferr_cnt = 0;
  int         nvec = 0;
  int         nerr = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    ev_t e;
    if (rst_ni) begin
      if (rx_dv_o) begin
        e.ferr = 1'b0; e.data = rx_byte_o; e.cyc = cyc;
        obs.push_back(e);
      end
      if (frame_err_o) begin
        e.ferr = 1'b1; e.data = rx_byte_o; e.cyc = cyc;
        obs.push_back(e);
        ferr_cnt <= ferr_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Reference: a frame whose start edge is driven just after clock edge c0
  // reaches rx_s S edges later, is registered one edge after that, checked at
  // start-bit centre after half+1 more edges, and the stop centre lies nine
  // bit periods further on; the strobe is visible right after that edge.
  task automatic model_frame(input logic [7:0] d, input int cpb_prog, input bit stop_ok, input int c0);
    ev_t e;
    int  cpb;
    int  half;
    cpb    = (cpb_prog < MinCpb) ? MinCpb : cpb_prog;
    half   = (cpb - 1) / 2;
    e.cyc  = c0 + S + 2 + half + 9 * cpb;
    e.ferr = !stop_ok;
    if (stop_ok) begin
      last_good = d;
    end
    e.data = last_good;
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx_i = v;
    step(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input int cpb_prog, input bit stop_ok, input int low_hold);
    int bitlen;
    bitlen = (cpb_prog < MinCpb) ? MinCpb : cpb_prog;
    model_frame(d, cpb_prog, stop_ok, cyc);
    drive_bit(1'b0, bitlen);
    for (int i = 0; i < 8; i++) begin
      drive_bit(d[i], bitlen);
      if (i == 4) chk("busy_mid_frame", {31'd0, busy_o}, 32'd1);
    end
    drive_bit(stop_ok, bitlen);
    if (!stop_ok) begin
      drive_bit(1'b0, low_hold);
      if (low_hold >= 8) chk("break_while_low", {31'd0, break_o}, 32'd1);
    end
    rx_i = 1'b1;
  endtask

  task automatic check_events(input string name);
    ev_t e;
    ev_t o;
    for (int i = 0; i < 3000 && obs.size() < exp_q.size(); i++) step(1);
    step(4);
    chk({name, "_count"}, obs.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs.size() > 0) begin
        o = obs.pop_front();
        chk({name, "_kind"}, {31'd0, o.ferr}, {31'd0, e.ferr});
        chk({name, "_byte"}, {24'd0, o.data}, {24'd0, e.data});
        chk({name, "_cycle"}, o.cyc, e.cyc);
      end
    end
    obs.delete();
  endtask

  vec_t tv[7];

  initial begin
    int   acc_ferr;
    int   base_ferr;
    logic [7:0] c3;

    tv[0] = '{8'hA5, 16, 1'b1, 0, 20, 8'hA5, 1'b0};
    tv[1] = '{8'h55, 16, 1'b0, 40, 20, 8'hA5, 1'b1};
    tv[2] = '{8'h81, 16, 1'b1, 0, 20, 8'h81, 1'b0};
    tv[3] = '{8'h00, 16, 1'b1, 0, 0, 8'h00, 1'b0};
    tv[4] = '{8'hFF, 16, 1'b1, 0, 20, 8'hFF, 1'b0};
    tv[5] = '{8'h00, 2, 1'b1, 0, 0, 8'h00, 1'b0};
    tv[6] = '{8'hFF, 2, 1'b1, 0, 20, 8'hFF, 1'b0};

    // Reset state.
    #3;
    chk("rst_rx_dv", {31'd0, rx_dv_o}, 32'd0);
    chk("rst_rx_byte", {24'd0, rx_byte_o}, 32'h00);
    chk("rst_frame_err", {31'd0, frame_err_o}, 32'd0);
    chk("rst_break", {31'd0, break_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    step(2);
    rst_ni = 1'b1;
    step(5);

    // Table-driven frames: framing, frame error/break, back-to-back, clamp.
    acc_ferr  = 0;
    base_ferr = ferr_cnt;
    foreach (tv[k]) begin
      clks_per_bit_i = 16'(tv[k].cpb);
      send_frame(tv[k].data, tv[k].cpb, tv[k].stop_ok, tv[k].hold);
      acc_ferr += int'(tv[k].exp_ferr);
      if (tv[k].gap > 0) begin
        step(tv[k].gap);
        chk("vec_rx_byte", {24'd0, rx_byte_o}, {24'd0, tv[k].exp_byte});
        chk("vec_break_clear", {31'd0, break_o}, 32'd0);
        chk("vec_busy_idle", {31'd0, busy_o}, 32'd0);
        chk("vec_frame_errs", ferr_cnt - base_ferr, acc_ferr);
        acc_ferr  = 0;
        base_ferr = ferr_cnt;
      end
    end
    check_events("table");

    // Start glitch shorter than half a bit, then a real frame.
    clks_per_bit_i = 16'd16;
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 30);
    chk("glitch_busy", {31'd0, busy_o}, 32'd0);
    check_events("glitch");
    send_frame(8'h3C, 16, 1'b1, 0);
    step(20);
    chk("after_glitch_byte", {24'd0, rx_byte_o}, 32'h3C);
    check_events("after_glitch");

    // Reset in the middle of data bit 4 of 0xC3.
    c3 = 8'hC3;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(c3[i], 16);
    drive_bit(c3[4], 8);
    rst_ni = 1'b0;
    #1;
    chk("midrst_rx_byte", {24'd0, rx_byte_o}, 32'h00);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_rx_dv", {31'd0, rx_dv_o}, 32'd0);
    step(3);
    rst_ni = 1'b1;
    rx_i = 1'b1;
    last_good = 8'h00;
    step(30);
    chk("postrst_rx_byte", {24'd0, rx_byte_o}, 32'h00);
    check_events("midrst");
    send_frame(8'h5A, 16, 1'b1, 0);
    step(20);
    chk("postrst_frame", {24'd0, rx_byte_o}, 32'h5A);
    check_events("postrst");

    // Period change mid-frame applies only from the next frame.
    clks_per_bit_i = 16'd16;
    fork
      send_frame(8'h96, 16, 1'b1, 0);
      begin
        step(60);
        clks_per_bit_i = 16'd32;
      end
    join
    step(20);
    send_frame(8'h69, 32, 1'b1, 0);
    step(20);
    chk("cpb_change_byte", {24'd0, rx_byte_o}, 32'h69);
    check_events("cpb_change");

    // Randomized frames against the reference.
    for (int k = 0; k < 16; k++) begin
      int         cpb;
      logic [7:0] d;
      bit         ok;
      int         hold;
      int         gap;
      cpb  = $urandom_range(1, 20);
      d    = 8'($urandom);
      ok   = ($urandom_range(0, 5) != 0);
      hold = ok ? 0 : $urandom_range(0, 30);
      gap  = ok ? $urandom_range(0, 6) : $urandom_range(2, 8);
      clks_per_bit_i = 16'(cpb);
      send_frame(d, cpb, ok, hold);
      step(gap);
    end
    step(10);
    check_events("random");
    chk("random_last_byte", {24'd0, rx_byte_o}, {24'd0, last_good});
    chk("random_busy_idle", {31'd0, busy_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
